note_scroll_ctrl: RTL and testbench



---
 rtl/note_lane_pkg.sv | 30 +++
 rtl/note_scroll_ctrl_if.sv | 27 ++
 rtl/note_scroll_ctrl_scroll_tick_gen.sv | 53 +++++
 rtl/note_scroll_ctrl.sv | 161 ++++++++++++++++
 tb/tb_note_scroll_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_lane_pkg.sv
// rtl/note_lane_pkg.sv - shared constants, state encoding and chart entry type for the note-lane sequencer
package note_lane_pkg;

    localparam int NUM_SLOTS = 10;
    localparam int CELL_W    = 7;
    localparam int OFFSET_W  = 3;

    localparam logic [OFFSET_W-1:0] OFFSET_MAX       = OFFSET_W'(CELL_W - 1);
    localparam logic [OFFSET_W-1:0] JUDGE_MAX_OFFSET = OFFSET_W'(3);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic red;
        logic blue;
        logic last;
    } chart_entry_t;

    // Slot NUM_SLOTS-1 is the entry edge; the caller passes the surviving upper slots only.
    function automatic logic [NUM_SLOTS-1:0] shift_in(input logic [NUM_SLOTS-2:0] upper,
                                                      input logic              bit_in);
        return {bit_in, upper};
    endfunction

endpackage

// File: rtl/note_scroll_ctrl_if.sv
// rtl/note_scroll_ctrl_if.sv - chart entry valid/ready stream between chart source and sequencer
interface note_scroll_ctrl_if;
    import note_lane_pkg::*;

    logic chart_valid;
    logic chart_red;
    logic chart_blue;
    logic chart_last;
    logic chart_ready;

    modport master (
        output chart_valid,
        output chart_red,
        output chart_blue,
        output chart_last,
        input  chart_ready
    );

    modport slave (
        input  chart_valid,
        input  chart_red,
        input  chart_blue,
        input  chart_last,
        output chart_ready
    );

endinterface

// File: rtl/note_scroll_ctrl_scroll_tick_gen.sv
// rtl/note_scroll_ctrl_scroll_tick_gen.sv - TICK_DIV prescaler and 0..6 sub-cell offset with wrap detection
module scroll_tick_gen
    import note_lane_pkg::*;
#(
    parameter int TICK_DIV = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                active,
    input  logic                enable,
    output logic                tick,
    output logic                shift_tick,
    output logic [OFFSET_W-1:0] offset
);

    localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic                run_en;

    always_comb begin
        run_en     = active & enable;
        tick       = run_en & (cnt_q == CNT_MAX);
        shift_tick = tick & (offset_q == OFFSET_MAX);
        cnt_d      = cnt_q;
        offset_d   = offset_q;
        if (clear) begin
            cnt_d    = '0;
            offset_d = '0;
        end else if (tick) begin
            cnt_d    = '0;
            offset_d = shift_tick ? '0 : offset_q + 1'b1;
        end else if (run_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            offset_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
        end
    end

    assign offset = offset_q;

endmodule

// File: rtl/note_scroll_ctrl.sv
// rtl/note_scroll_ctrl.sv - note-lane sequencer: pulls chart entries, scrolls 10-slot red/blue windows
// Optional hit/miss judging on slot 0 is built when NOTE_JUDGE_EN is defined.
module note_scroll_ctrl
    import note_lane_pkg::*;
#(
    parameter int TICK_DIV = 1000000,
    parameter int UFLOW_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 enable,
    note_scroll_ctrl_if.slave    chart,
    output logic [NUM_SLOTS-1:0] red_notes,
    output logic [NUM_SLOTS-1:0] blue_notes,
    output logic [OFFSET_W-1:0]  offset,
    output logic                 step_strobe,
    output logic                 busy,
    output logic                 done,
    output logic [UFLOW_W-1:0]   uflow_cnt
`ifdef NOTE_JUDGE_EN
    ,
    input  logic                 hit_red,
    input  logic                 hit_blue,
    output logic                 hit_pulse,
    output logic                 miss_pulse
`endif
);

    state_t               state_q;
    logic                 done_q, step_q;
    logic [NUM_SLOTS-1:0] red_q, red_d, blue_q, blue_d;
    logic [UFLOW_W-1:0]   uflow_q, uflow_d;
    logic [OFFSET_W-1:0]  offset_w;
    logic                 launch, active, tick, shift_tick, accept, drain_empty;
    logic                 red_hit, blue_hit;
    chart_entry_t         entry;

    assign launch = start & ((state_q == IDLE) | (state_q == DONE));
    assign active = (state_q == RUN) | (state_q == DRAIN);
    assign entry  = '{red: chart.chart_red, blue: chart.chart_blue, last: chart.chart_last};

    // Never consume an entry while reset is held, even if the state register still says RUN.
    assign chart.chart_ready = ~rst & (state_q == RUN) & shift_tick;
    assign accept            = chart.chart_ready & chart.chart_valid;
    assign drain_empty       = (red_q[NUM_SLOTS-1:1] == '0) && (blue_q[NUM_SLOTS-1:1] == '0);

    scroll_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .clear      (launch),
        .active     (active),
        .enable     (enable),
        .tick       (tick),
        .shift_tick (shift_tick),
        .offset     (offset_w)
    );

`ifdef NOTE_JUDGE_EN
    logic judge_open, hit_q, hit_d, miss_q, miss_d;

    assign judge_open = (offset_w <= JUDGE_MAX_OFFSET);
    assign red_hit    = hit_red & red_q[0] & judge_open;
    assign blue_hit   = hit_blue & blue_q[0] & judge_open;

    always_comb begin
        hit_d  = red_hit | blue_hit;
        miss_d = shift_tick & ((red_q[0] & ~red_hit) | (blue_q[0] & ~blue_hit));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
`else
    assign red_hit  = 1'b0;
    assign blue_hit = 1'b0;
`endif

    // Red wins a cell that is marked both colours; bit 0 falls off the exit edge on every shift.
    always_comb begin
        red_d   = red_q;
        blue_d  = blue_q;
        uflow_d = uflow_q;
        if (launch) begin
            red_d   = '0;
            blue_d  = '0;
            uflow_d = '0;
        end else if (shift_tick) begin
            red_d  = shift_in(red_q[NUM_SLOTS-1:1], accept & entry.red);
            blue_d = shift_in(blue_q[NUM_SLOTS-1:1], accept & entry.blue & ~entry.red);
            if ((state_q == RUN) && !chart.chart_valid && (uflow_q != '1)) begin
                uflow_d = uflow_q + 1'b1;
            end
        end else begin
            red_d[0]  = red_q[0] & ~red_hit;
            blue_d[0] = blue_q[0] & ~blue_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            red_q   <= '0;
            blue_q  <= '0;
            uflow_q <= '0;
            step_q  <= 1'b0;
        end else begin
            red_q   <= red_d;
            blue_q  <= blue_d;
            uflow_q <= uflow_d;
            step_q  <= tick;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (accept && entry.last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (shift_tick && drain_empty) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign red_notes   = red_q;
    assign blue_notes  = blue_q;
    assign offset      = offset_w;
    assign step_strobe = step_q;
    assign busy        = active;
    assign done        = done_q;
    assign uflow_cnt   = uflow_q;

endmodule

// File: tb/tb_note_scroll_ctrl.sv
// tb/tb_note_scroll_ctrl.sv - self-checking bench for note_scroll_ctrl (TICK_DIV=4, UFLOW_W 8 and 2)
module tb_note_scroll_ctrl;
    import note_lane_pkg::*;

    localparam int TD     = 4;
    localparam int STEP   = CELL_W * TD;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst, start, enable, c_valid, c_red, c_blue, c_last;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    note_scroll_ctrl_if u_if1 ();
    note_scroll_ctrl_if u_if2 ();
    assign u_if1.chart_valid = c_valid;
    assign u_if1.chart_red   = c_red;
    assign u_if1.chart_blue  = c_blue;
    assign u_if1.chart_last  = c_last;
    assign u_if2.chart_valid = c_valid;
    assign u_if2.chart_red   = c_red;
    assign u_if2.chart_blue  = c_blue;
    assign u_if2.chart_last  = c_last;

    logic [NUM_SLOTS-1:0] red1, blue1, red2, blue2;
    logic [OFFSET_W-1:0]  off1, off2;
    logic                 step1, busy1, done1, step2, busy2, done2;
    logic [7:0]           uf1;
    logic [1:0]           uf2;
`ifdef NOTE_JUDGE_EN
    logic hit_red, hit_blue, hit1, miss1, hit2, miss2;
`endif

    note_scroll_ctrl #(.TICK_DIV(TD), .UFLOW_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .chart(u_if1),
        .red_notes(red1), .blue_notes(blue1), .offset(off1), .step_strobe(step1),
        .busy(busy1), .done(done1), .uflow_cnt(uf1)
`ifdef NOTE_JUDGE_EN
        , .hit_red(hit_red), .hit_blue(hit_blue), .hit_pulse(hit1), .miss_pulse(miss1)
`endif
    );

    note_scroll_ctrl #(.TICK_DIV(TD), .UFLOW_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .enable(enable), .chart(u_if2),
        .red_notes(red2), .blue_notes(blue2), .offset(off2), .step_strobe(step2),
        .busy(busy2), .done(done2), .uflow_cnt(uf2)
`ifdef NOTE_JUDGE_EN
        , .hit_red(hit_red), .hit_blue(hit_blue), .hit_pulse(hit2), .miss_pulse(miss2)
`endif
    );

    // Reference model: progress count of enabled active cycles plus queues of slot contents.
    int ms = M_IDLE, prog = 0, uf = 0;
    bit mr[$], mb[$];
    bit m_step = 0, m_done = 0;
`ifdef NOTE_JUDGE_EN
    bit m_hit = 0, m_miss = 0;
`endif

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [NUM_SLOTS-1:0] pack_q(input bit q[$]);
        logic [NUM_SLOTS-1:0] v = '0;
        for (int i = 0; i < NUM_SLOTS; i++) v[i] = q[i];
        return v;
    endfunction

    function automatic int umin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic clear_windows();
        mr.delete();
        mb.delete();
        repeat (NUM_SLOTS) begin
            mr.push_back(1'b0);
            mb.push_back(1'b0);
        end
    endtask

    task automatic model_step();
        bit new_r, new_b, was_drain;
        int off;
        m_step = 0;
        m_done = 0;
`ifdef NOTE_JUDGE_EN
        m_hit  = 0;
        m_miss = 0;
`endif
        if (rst) begin
            ms = M_IDLE; prog = 0; uf = 0;
            clear_windows();
            return;
        end
        off = (prog / TD) % CELL_W;
`ifdef NOTE_JUDGE_EN
        if (hit_red && mr[0] && off <= 3) begin mr[0] = 0; m_hit = 1; end
        if (hit_blue && mb[0] && off <= 3) begin mb[0] = 0; m_hit = 1; end
`endif
        if ((ms == M_IDLE || ms == M_DONE) && start) begin
            ms = M_RUN; prog = 0; uf = 0;
            clear_windows();
        end else if ((ms == M_RUN || ms == M_DRAIN) && enable) begin
            prog++;
            m_step = (prog % TD) == 0;
            if (prog % STEP == 0) begin
                new_r = 0; new_b = 0;
                was_drain = (ms == M_DRAIN);
                if (!was_drain) begin
                    if (c_valid) begin
                        new_r = c_red;
                        new_b = c_blue && !c_red;
                        if (c_last) ms = M_DRAIN;
                    end else begin
                        uf++;
                    end
                end
`ifdef NOTE_JUDGE_EN
                m_miss = mr[0] || mb[0];
`endif
                void'(mr.pop_front());
                void'(mb.pop_front());
                mr.push_back(new_r);
                mb.push_back(new_b);
                if (was_drain && pack_q(mr) == 0 && pack_q(mb) == 0) begin
                    ms = M_DONE; m_done = 1; prog = 0;
                end
            end
        end
    endtask

    task automatic check_inst(string tag, logic [NUM_SLOTS-1:0] r, logic [NUM_SLOTS-1:0] b,
                              logic [OFFSET_W-1:0] o, logic rd, logic st, logic bz, logic dn,
                              logic [31:0] ufa, int uf_max);
        bit exp_rd;
        exp_rd = !rst && ms == M_RUN && enable && ((prog + 1) % STEP == 0);
        chk({tag, " red_notes"},  32'(r),  32'(pack_q(mr)));
        chk({tag, " blue_notes"}, 32'(b),  32'(pack_q(mb)));
        chk({tag, " offset"},     32'(o),  32'((prog / TD) % CELL_W));
        chk({tag, " chart_ready"}, 32'(rd), 32'(exp_rd));
        chk({tag, " step_strobe"}, 32'(st), 32'(m_step));
        chk({tag, " busy"},       32'(bz), 32'(ms == M_RUN || ms == M_DRAIN));
        chk({tag, " done"},       32'(dn), 32'(m_done));
        chk({tag, " uflow_cnt"},  ufa,     32'(umin(uf, uf_max)));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check_inst("u1", red1, blue1, off1, u_if1.chart_ready, step1, busy1, done1, 32'(uf1), 255);
            check_inst("u2", red2, blue2, off2, u_if2.chart_ready, step2, busy2, done2, 32'(uf2), 3);
`ifdef NOTE_JUDGE_EN
            chk("u1 hit_pulse", 32'(hit1), 32'(m_hit));
            chk("u1 miss_pulse", 32'(miss1), 32'(m_miss));
            chk("u2 hit_pulse", 32'(hit2), 32'(m_hit));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(string name);
        bit ok = 0;
        for (int n = 0; n < 80; n++) begin
            #1;
            if (u_if1.chart_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #2;
        end
        chk({name, " ready seen"}, 32'(ok), 32'd1);
        cyc();
    endtask

    task automatic wait_offset(int v);
        bit ok = 0;
        for (int n = 0; n < 60; n++) begin
            if (32'(off1) == v) begin
                ok = 1;
                break;
            end
            cyc();
        end
        chk("offset reached", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int n = 0; n < 400; n++) begin
            if (done1) begin
                ok = 1;
                break;
            end
            cyc();
        end
        chk("done seen", 32'(ok), 32'd1);
    endtask

    typedef struct {
        bit v, r, b, l;
        bit er, eb;
        int eu;
    } vec_t;

    vec_t tbl[11];
    int   first, nready;

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 1, 0, 0};
        tbl[2]  = '{1, 0, 1, 0, 0, 1, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 0, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 2};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 3};
        tbl[7]  = '{1, 0, 1, 0, 0, 1, 3};
        tbl[8]  = '{0, 0, 0, 1, 0, 0, 4};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 5};
        tbl[10] = '{1, 1, 0, 1, 1, 0, 5};

        rst = 1; start = 0; enable = 1;
        c_valid = 0; c_red = 0; c_blue = 0; c_last = 0;
`ifdef NOTE_JUDGE_EN
        hit_red = 0; hit_blue = 0;
`endif
        cyc();
        chk_on = 1;
        cyc();
        chk("reset red_notes", 32'(red1), 32'd0);
        chk("reset offset", 32'(off1), 32'd0);
        chk("reset busy", 32'(busy1), 32'd0);
        chk("reset uflow", 32'(uf1), 32'd0);
        rst = 0;

        // Single red entry with last held: first consumption on the 28th RUN cycle.
        c_valid = 1; c_red = 1; c_last = 1;
        start = 1; cyc(); start = 0;
        first = 0; nready = 0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (u_if1.chart_ready) begin
                nready++;
                if (first == 0) first = k;
            end
            @(posedge clk);
            #2;
        end
        chk("first ready cycle", 32'(first), 32'd28);
        chk("ready count", 32'(nready), 32'd1);
        chk("entry at slot 9", 32'(red1), 32'h200);
        repeat (240) cyc();
        chk("entry at slot 0", 32'(red1), 32'h001);
        chk("busy in drain", 32'(busy1), 32'd1);
        repeat (28) cyc();
        chk("drain empty", 32'(red1), 32'd0);
        chk("done pulse", 32'(done1), 32'd1);
        chk("idle after done", 32'(busy1), 32'd0);
        cyc();
        chk("done one cycle", 32'(done1), 32'd0);

        // Entry-encoding table: one row per shift tick.
        start = 1; cyc(); start = 0;
        for (int i = 0; i < 11; i++) begin
            c_valid = tbl[i].v; c_red = tbl[i].r; c_blue = tbl[i].b; c_last = tbl[i].l;
            wait_ready("table");
            chk("table red[9]", 32'(red1[9]), 32'(tbl[i].er));
            chk("table blue[9]", 32'(blue1[9]), 32'(tbl[i].eb));
            chk("table uflow8", 32'(uf1), 32'(tbl[i].eu));
            chk("table uflow2", 32'(uf2), 32'(umin(tbl[i].eu, 3)));
        end
        chk("table drain busy", 32'(busy1), 32'd1);
        c_valid = 0; c_last = 0;
        wait_done();

        // Pause two cycles into the offset-4 step, then resume.
        start = 1; cyc(); start = 0;
        c_valid = 1; c_red = 1; c_blue = 0; c_last = 0;
        wait_ready("pause setup");
        c_valid = 0;
        wait_offset(4);
        cyc(); cyc();
        enable = 0;
        repeat (50) cyc();
        chk("pause offset", 32'(off1), 32'd4);
        chk("pause red", 32'(red1), 32'h200);
        chk("pause step", 32'(step1), 32'd0);
        enable = 1;
        cyc();
        chk("resume offset hold", 32'(off1), 32'd4);
        cyc();
        chk("resume offset step", 32'(off1), 32'd5);
        chk("resume strobe", 32'(step1), 32'd1);
        start = 1; cyc(); start = 0;
        chk("start in run red", 32'(red1), 32'h200);
        chk("start in run offset", 32'(off1), 32'd5);

        // Reset while draining with notes still on the lane.
        c_valid = 1; c_red = 0; c_blue = 1; c_last = 1;
        wait_ready("drain entry");
        chk("drain red", 32'(red1), 32'h100);
        chk("drain blue", 32'(blue1), 32'h200);
        repeat (5) cyc();
        rst = 1; cyc(); rst = 0;
        chk("abort red", 32'(red1), 32'd0);
        chk("abort blue", 32'(blue1), 32'd0);
        chk("abort busy", 32'(busy1), 32'd0);
        chk("abort offset", 32'(off1), 32'd0);

`ifdef NOTE_JUDGE_EN
        start = 1; cyc(); start = 0;
        for (int j = 0; j < 10; j++) begin
            c_valid = 1; c_red = (j == 0); c_blue = (j == 1); c_last = 0;
            wait_ready("judge fill");
        end
        chk("judge red slot0", 32'(red1), 32'h001);
        chk("judge blue slot1", 32'(blue1), 32'h002);
        c_red = 0; c_blue = 0;
        wait_offset(2);
        hit_red = 1; cyc(); hit_red = 0;
        chk("hit clears red", 32'(red1), 32'd0);
        chk("hit pulse", 32'(hit1), 32'd1);
        hit_blue = 1; cyc(); hit_blue = 0;
        chk("empty hit no pulse", 32'(hit1), 32'd0);
        wait_ready("judge advance");
        wait_ready("judge miss");
        chk("miss pulse", 32'(miss1), 32'd1);
        rst = 1; cyc(); rst = 0;
`endif

        // Randomized traffic checked every cycle against the model.
        for (int n = 0; n < 6000; n++) begin
            enable  = ($urandom % 10) != 0;
            start   = ($urandom % 40) == 0;
            rst     = ($urandom % 500) == 0;
            c_valid = ($urandom % 4) != 0;
            c_red   = ($urandom % 2) != 0;
            c_blue  = ($urandom % 2) != 0;
            c_last  = ($urandom % 8) == 0;
`ifdef NOTE_JUDGE_EN
            hit_red  = ($urandom % 6) == 0;
            hit_blue = ($urandom % 6) == 0;
`endif
            cyc();
        end
        rst = 0; start = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
